// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 strip driver: FSM states,
// per-LED bit count and the GRB colour layout of the staging/shift registers.
package ws2812_pkg;

  typedef enum logic [2:0] {IDLE, PRIME, SEND, STALL, LATCH} state_e;

  localparam int BITS_PER_LED = 24;

  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  // Counter width for a terminal count of p-1, never narrower than one bit.
  function automatic int cnt_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  localparam int BIT_IDX_W = cnt_w(BITS_PER_LED);

endpackage

// File: rtl/ws2812_bit_encoder.sv
// One WS2812 bit period: counts BIT_CYCLES while enabled and drives the line
// high for T0H or T1H cycles depending on the bit value.
module ws2812_bit_encoder #(
  parameter int BIT_CYCLES = 125,
  parameter int T0H_CYCLES = 35,
  parameter int T1H_CYCLES = 70
) (
  input  logic clk_led,
  input  logic rst,
  input  logic en,
  input  logic bit_value,
  output logic strip_bit,
  output logic bit_last
);
  import ws2812_pkg::*;

  localparam int CW = cnt_w(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);

  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  // Counter parks at zero whenever disabled so the next bit starts cleanly.
  always_comb begin
    bit_cnt_d = '0;
    if (en && (bit_cnt_q != CNT_LAST)) bit_cnt_d = bit_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_led) begin
    if (rst) bit_cnt_q <= '0;
    else     bit_cnt_q <= bit_cnt_d;
  end

  assign bit_last  = en && (bit_cnt_q == CNT_LAST);
  assign strip_bit = en && (bit_cnt_q < (bit_value ? T1H : T0H));

endmodule

// File: rtl/ws2812_strip_driver.sv
// Frame sequencer: fetches colours from the LED buffer one address at a time,
// prefetching the next LED while the current one is serialised.
module ws2812_strip_driver #(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 10,
  parameter int BIT_CYCLES        = 125,
  parameter int T0H_CYCLES        = 35,
  parameter int T1H_CYCLES        = 70,
  parameter int RESET_CYCLES      = 5000,
  parameter int SETTLE_CYCLES     = 3
) (
  input  logic                         clk_led,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   red_in,
  input  logic [7:0]                   green_in,
  input  logic [7:0]                   blue_in,
  input  logic                         color_valid,
  output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
  output logic                         strip_out,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         underrun
);
  import ws2812_pkg::*;

  localparam int AW = LED_ADDRESS_WIDTH;
  localparam int LW = cnt_w(NUM_LEDS);
  localparam int RW = cnt_w(RESET_CYCLES);
  localparam int SW = cnt_w(SETTLE_CYCLES + 1);

  localparam logic [AW-1:0]        ADDR_LAST    = AW'(NUM_LEDS - 1);
  localparam logic [LW-1:0]        LED_LAST     = LW'(NUM_LEDS - 1);
  localparam logic [RW-1:0]        LAT_LAST     = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]        SETTLE_MAX   = SW'(SETTLE_CYCLES);
  localparam logic [BIT_IDX_W-1:0] BIT_IDX_LAST = BIT_IDX_W'(BITS_PER_LED - 1);

  state_e                 state_q, state_d;
  logic [23:0]            sr_q, sr_d;
  logic [23:0]            stage_q, stage_d;
  logic                   stage_valid_q, stage_valid_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [LW-1:0]          led_cnt_q, led_cnt_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [RW-1:0]          lat_cnt_q, lat_cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic                   underrun_q, underrun_d;
  logic                   load, fetch_en, capture;
  logic                   bit_last, strip_bit;

  ws2812_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_enc (
    .clk_led   (clk_led),
    .rst       (rst),
    .en        (state_q == SEND),
    .bit_value (sr_q[23]),
    .strip_bit (strip_bit),
    .bit_last  (bit_last)
  );

  // Prefetch only while another LED remains to be requested in this frame.
  assign fetch_en = (state_q == PRIME) ||
                    (((state_q == SEND) || (state_q == STALL)) && (led_cnt_q != LED_LAST));
  assign capture  = color_valid && (settle_q >= SETTLE_MAX) && !stage_valid_q && fetch_en;

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    stage_d       = stage_q;
    stage_valid_d = stage_valid_q;
    bit_idx_d     = bit_idx_q;
    led_cnt_d     = led_cnt_q;
    addr_d        = addr_q;
    lat_cnt_d     = lat_cnt_q;
    frame_done_d  = 1'b0;
    underrun_d    = 1'b0;
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) state_d = PRIME;
      end
      PRIME: begin
        if (stage_valid_q) begin
          load      = 1'b1;
          led_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (bit_last) begin
          if (bit_idx_q != BIT_IDX_LAST) begin
            sr_d      = {sr_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            bit_idx_d = '0;
            if (led_cnt_q == LED_LAST) begin
              addr_d    = '0;
              lat_cnt_d = '0;
              state_d   = LATCH;
            end else if (stage_valid_q) begin
              load      = 1'b1;
              led_cnt_d = led_cnt_q + 1'b1;
            end else begin
              underrun_d = 1'b1;
              state_d    = STALL;
            end
          end
        end
      end
      STALL: begin
        if (stage_valid_q) begin
          load      = 1'b1;
          led_cnt_d = led_cnt_q + 1'b1;
          state_d   = SEND;
        end
      end
      LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sr_d          = stage_q;
      stage_valid_d = 1'b0;
      if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
    end else if (capture) begin
      stage_d[G_MSB:G_LSB] = green_in;
      stage_d[R_MSB:R_LSB] = red_in;
      stage_d[B_MSB:B_LSB] = blue_in;
      stage_valid_d        = 1'b1;
    end

    // Buffer data can lag an address change, so restart the settle window.
    settle_d = settle_q;
    if (addr_d != addr_q)            settle_d = '0;
    else if (settle_q != SETTLE_MAX) settle_d = settle_q + 1'b1;
  end

  always_ff @(posedge clk_led) begin
    if (rst) begin
      state_q       <= IDLE;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      bit_idx_q     <= '0;
      led_cnt_q     <= '0;
      addr_q        <= '0;
      settle_q      <= '0;
      lat_cnt_q     <= '0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      bit_idx_q     <= bit_idx_d;
      led_cnt_q     <= led_cnt_d;
      addr_q        <= addr_d;
      settle_q      <= settle_d;
      lat_cnt_q     <= lat_cnt_d;
      frame_done_q  <= frame_done_d;
      underrun_q    <= underrun_d;
    end
  end

  // Shift register only matters while SEND is active, so it carries no reset.
  always_ff @(posedge clk_led) begin
    sr_q <= sr_d;
  end

  assign next_led_request_address = addr_q;
  assign strip_out                = strip_bit;
  assign busy                     = (state_q != IDLE);
  assign frame_done               = frame_done_q;
  assign underrun                 = underrun_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Directed bench for ws2812_strip_driver with a small LED-buffer model that has
// two-cycle read latency and a registered color_valid.
module tb_ws2812_strip_driver;
  localparam int NUM_LEDS = 3;
  localparam int AW       = 10;
  localparam int BITC     = 10;
  localparam int T0H      = 3;
  localparam int T1H      = 7;
  localparam int RSTC     = 20;
  localparam int SETTLE   = 3;

  logic          clk_led = 1'b0;
  logic          rst     = 1'b1;
  logic          start   = 1'b0;
  logic [7:0]    red_in, green_in, blue_in;
  logic          color_valid;
  logic [AW-1:0] addr;
  logic          strip_out, busy, frame_done, underrun;

  always #5 clk_led = ~clk_led;

  ws2812_strip_driver #(
    .NUM_LEDS          (NUM_LEDS),
    .LED_ADDRESS_WIDTH (AW),
    .BIT_CYCLES        (BITC),
    .T0H_CYCLES        (T0H),
    .T1H_CYCLES        (T1H),
    .RESET_CYCLES      (RSTC),
    .SETTLE_CYCLES     (SETTLE)
  ) dut (
    .clk_led                  (clk_led),
    .rst                      (rst),
    .start                    (start),
    .red_in                   (red_in),
    .green_in                 (green_in),
    .blue_in                  (blue_in),
    .color_valid              (color_valid),
    .next_led_request_address (addr),
    .strip_out                (strip_out),
    .busy                     (busy),
    .frame_done               (frame_done),
    .underrun                 (underrun)
  );

  // Buffer contents as {G,R,B}.
  logic [23:0] mem [NUM_LEDS] = '{24'hFF0080, 24'h123456, 24'hA55A0F};
  logic [71:0] exp_frame;

  logic [AW-1:0] a1 = '0, addr_prev = '0;
  logic [23:0]   dq = '0;
  logic          vq = 1'b0;
  int            age = 0;
  logic          stale_mode = 1'b0, hold_led1 = 1'b0;

  always @(posedge clk_led) begin
    a1        <= addr;
    dq        <= (a1 < AW'(NUM_LEDS)) ? mem[a1[1:0]] : 24'h0;
    vq        <= (a1 == addr) && !(hold_led1 && (addr == AW'(1)) && (age < 300));
    addr_prev <= addr;
    age       <= (addr != addr_prev) ? 0 : age + 1;
  end

  assign color_valid = stale_mode | vq;
  assign green_in    = dq[23:16];
  assign red_in      = dq[15:8];
  assign blue_in     = dq[7:0];

  logic          rec = 1'b0;
  logic          q_strip[$], q_fd[$], q_ur[$], q_busy[$];
  logic [AW-1:0] addr_trace[$];

  always @(negedge clk_led) begin
    if (rec) begin
      q_strip.push_back(strip_out);
      q_fd.push_back(frame_done);
      q_ur.push_back(underrun);
      q_busy.push_back(busy);
      if ((addr_trace.size() == 0) || (addr_trace[addr_trace.size()-1] != addr))
        addr_trace.push_back(addr);
    end
  end

  int          passed = 0, total = 0;
  logic        timed_out;
  int          rises[$], highs[$];
  int          fd_idx, fd_cnt, ur_idx, ur_cnt, bad_highs;
  logic [71:0] stream;

  task automatic run_frame(input int extra_start);
    q_strip.delete(); q_fd.delete(); q_ur.delete(); q_busy.delete(); addr_trace.delete();
    timed_out = 1'b1;
    @(posedge clk_led); #1;
    start = 1'b1;
    rec   = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_led); #1;
      start = (c == extra_start);
      if (frame_done) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk_led); #1;
    rec = 1'b0;
  endtask

  // Turns the recorded line into bit periods and a decoded bit stream.
  task automatic decode();
    int h;
    rises.delete(); highs.delete();
    fd_idx = -1; fd_cnt = 0; ur_idx = -1; ur_cnt = 0; bad_highs = 0; stream = '0;
    for (int i = 0; i < q_strip.size(); i++) begin
      if (q_strip[i] && ((i == 0) || !q_strip[i-1])) begin
        h = 0;
        for (int j = i; (j < q_strip.size()) && q_strip[j]; j++) h++;
        rises.push_back(i);
        highs.push_back(h);
      end
      if (q_fd[i]) begin fd_cnt++; if (fd_idx < 0) fd_idx = i; end
      if (q_ur[i]) begin ur_cnt++; if (ur_idx < 0) ur_idx = i; end
    end
    for (int k = 0; (k < highs.size()) && (k < 72); k++) begin
      stream[71-k] = (highs[k] == T1H);
      if ((highs[k] != T1H) && (highs[k] != T0H)) bad_highs++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_led);
    #1;
    total++; if (strip_out !== 1'b0) $display("FAIL reset_strip got %b want 0", strip_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun); else passed++;
    total++; if (addr !== '0) $display("FAIL reset_addr got %0d want 0", addr); else passed++;
    rst = 1'b0;
    repeat (5) @(posedge clk_led);
  endtask

  task automatic test_first_led();
    int bad_per;
    run_frame(-1);
    decode();
    bad_per = 0;
    for (int i = 0; i < 24; i++)
      if ((i + 1 >= rises.size()) || (rises[i+1] - rises[i] != BITC)) bad_per++;
    total++; if (timed_out !== 1'b0) $display("FAIL first_led_timeout got %b want 0", timed_out); else passed++;
    total++; if (stream[71:48] !== 24'hFF0080) $display("FAIL first_led_bits got %h want ff0080", stream[71:48]); else passed++;
    total++; if (bad_per !== 0) $display("FAIL first_led_periods got %0d bad want 0", bad_per); else passed++;
    total++; if (bad_highs !== 0) $display("FAIL first_led_high_times got %0d bad want 0", bad_highs); else passed++;
  endtask

  task automatic test_full_frame();
    int bad_per, late_high;
    run_frame(-1);
    decode();
    bad_per = 0;
    for (int i = 0; (i + 1) < rises.size(); i++) if (rises[i+1] - rises[i] != BITC) bad_per++;
    late_high = 0;
    if (rises.size() == 72)
      for (int i = rises[71] + highs[71]; i < q_strip.size(); i++) if (q_strip[i]) late_high++;
    total++; if (timed_out !== 1'b0) $display("FAIL frame_timeout got %b want 0", timed_out); else passed++;
    total++; if (rises.size() !== 72) $display("FAIL frame_bit_count got %0d want 72", rises.size()); else passed++;
    total++; if (stream !== exp_frame) $display("FAIL frame_bits got %h want %h", stream, exp_frame); else passed++;
    total++; if (bad_per !== 0) $display("FAIL frame_gaps got %0d bad periods want 0", bad_per); else passed++;
    total++; if (late_high !== 0) $display("FAIL latch_low got %0d high cycles want 0", late_high); else passed++;
    total++;
    if ((rises.size() != 72) || (fd_idx - rises[71] != BITC + RSTC))
      $display("FAIL latch_length got fd at %0d want last_rise+%0d", fd_idx, BITC + RSTC);
    else passed++;
    total++; if (fd_cnt !== 1) $display("FAIL frame_done_count got %0d want 1", fd_cnt); else passed++;
    total++;
    if ((fd_idx < 1) || ({q_busy[fd_idx-1], q_busy[fd_idx]} !== 2'b10))
      $display("FAIL busy_fall fd_idx %0d want busy 1 then 0 at frame_done", fd_idx);
    else passed++;
    total++;
    if ((q_busy.size() < 2) || ({q_busy[0], q_busy[1]} !== 2'b01))
      $display("FAIL busy_rise want 0 in start cycle then 1");
    else passed++;
    total++; if (ur_cnt !== 0) $display("FAIL frame_underrun got %0d want 0", ur_cnt); else passed++;
  endtask

  task automatic test_underrun();
    int bad_per;
    hold_led1 = 1'b1;
    run_frame(-1);
    hold_led1 = 1'b0;
    decode();
    bad_per = 0;
    for (int i = 0; (i + 1) < rises.size(); i++)
      if ((i != 23) && (rises[i+1] - rises[i] != BITC)) bad_per++;
    total++; if (timed_out !== 1'b0) $display("FAIL stall_timeout got %b want 0", timed_out); else passed++;
    total++; if (ur_cnt !== 1) $display("FAIL underrun_count got %0d want 1", ur_cnt); else passed++;
    total++;
    if ((rises.size() < 25) || (ur_idx !== rises[23] + BITC))
      $display("FAIL underrun_position got %0d want end of LED0 bit 23", ur_idx);
    else passed++;
    total++;
    if ((rises.size() < 25) || (rises[24] - rises[23] <= BITC))
      $display("FAIL stall_gap got no extended low period want > %0d", BITC);
    else passed++;
    total++; if (bad_per !== 0) $display("FAIL stall_other_periods got %0d bad want 0", bad_per); else passed++;
    total++; if (stream !== exp_frame) $display("FAIL stall_bits got %h want %h", stream, exp_frame); else passed++;
  endtask

  task automatic test_stale_data();
    stale_mode = 1'b1;
    run_frame(-1);
    stale_mode = 1'b0;
    decode();
    total++; if (timed_out !== 1'b0) $display("FAIL stale_timeout got %b want 0", timed_out); else passed++;
    total++; if (stream[47:24] !== mem[1]) $display("FAIL stale_led1 got %h want %h", stream[47:24], mem[1]); else passed++;
    total++; if (stream !== exp_frame) $display("FAIL stale_frame got %h want %h", stream, exp_frame); else passed++;
  endtask

  task automatic test_start_during_send();
    int late_busy;
    run_frame(100);
    decode();
    late_busy = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk_led); #1;
      if (busy) late_busy++;
    end
    total++; if (fd_cnt !== 1) $display("FAIL restart_frame_done got %0d want 1", fd_cnt); else passed++;
    total++; if (late_busy !== 0) $display("FAIL restart_busy got %0d busy cycles want 0", late_busy); else passed++;
    total++; if (stream !== exp_frame) $display("FAIL restart_bits got %h want %h", stream, exp_frame); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int bad_per;
    logic reached;
    @(posedge clk_led); #1;
    start = 1'b1;
    @(posedge clk_led); #1;
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk_led); #1;
      if (addr == AW'(2)) begin reached = 1'b1; break; end
    end
    for (int c = 0; c < 20 && reached; c++) begin
      if (strip_out) break;
      @(posedge clk_led); #1;
    end
    total++;
    if ((reached !== 1'b1) || (strip_out !== 1'b1))
      $display("FAIL abort_setup got reached=%b strip=%b want 1 1", reached, strip_out);
    else passed++;
    rst = 1'b1;
    @(posedge clk_led); #1;
    total++; if (strip_out !== 1'b0) $display("FAIL abort_strip got %b want 0", strip_out); else passed++;
    total++; if (addr !== '0) $display("FAIL abort_addr got %0d want 0", addr); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    rst = 1'b0;
    repeat (5) @(posedge clk_led);
    run_frame(-1);
    decode();
    bad_per = 0;
    for (int i = 0; (i + 1) < rises.size(); i++) if (rises[i+1] - rises[i] != BITC) bad_per++;
    total++; if (stream !== exp_frame) $display("FAIL post_abort_bits got %h want %h", stream, exp_frame); else passed++;
    total++; if ((bad_per !== 0) || (fd_cnt !== 1))
      $display("FAIL post_abort_timing got %0d bad periods %0d frame_done want 0 1", bad_per, fd_cnt);
    else passed++;
  endtask

  task automatic test_address_trace();
    logic [4*AW-1:0] trace;
    run_frame(-1);
    trace = '1;
    if (addr_trace.size() == 4)
      trace = {addr_trace[0], addr_trace[1], addr_trace[2], addr_trace[3]};
    total++; if (addr_trace.size() !== 4) $display("FAIL addr_trace_len got %0d want 4", addr_trace.size()); else passed++;
    total++;
    if (trace !== {AW'(0), AW'(1), AW'(2), AW'(0)})
      $display("FAIL addr_trace_seq got %h want sequence 0,1,2,0", trace);
    else passed++;
  endtask

  initial begin
    exp_frame = {mem[0], mem[1], mem[2]};
    test_reset();
    test_first_led();
    test_full_frame();
    test_underrun();
    test_stale_data();
    test_start_during_send();
    test_reset_mid_frame();
    test_address_trace();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
